// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, bubble encoding, PC step
// and a saturating increment used by the optional fetch counters.
package pipeline_pkg;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_WAIT = 2'd1,
      FS_DROP = 2'd2,
      FS_FULL = 2'd3
   } fetch_state_e;

   localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_STEP      = 32'd4;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and memory (slave).
interface fetch_stage_if;
   logic        ImemReq;
   logic [31:0] ImemAddr;
   logic        ImemAck;
   logic [31:0] ImemRdata;

   modport master (output ImemReq, output ImemAddr, input ImemAck, input ImemRdata);
   modport slave  (input ImemReq, input ImemAddr, output ImemAck, output ImemRdata);
endinterface

// File: rtl/fetch_skid.sv
// Skid buffer holding one fetched {address, instruction} pair while decode is stalled.
module fetch_skid (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [63:0] data_i,
   output logic [63:0] data_o
);

   logic [63:0] data_q;

   // Clear wins over load so a discarded entry can never be resurrected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= 64'h0;
      end else if (clear_i) begin
         data_q <= 64'h0;
      end else if (load_i) begin
         data_q <= data_i;
      end else begin
         data_q <= data_q;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding imem request FSM, skid buffer and IF/ID register.
// Define FETCH_PERF_EN to add the FetchCountF / FetchStallCountF counters.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          StallF,
   input  logic          StallD,
   input  logic          FlushD,
   input  logic          PCSrcW,
   input  logic [31:0]   ResultW,
   input  logic          BranchTakenD,
   input  logic [31:0]   BranchTargetD,
   input  logic          PCWrPendingF,
   fetch_stage_if.master imem,
   output logic [31:0]   PCF,
   output logic [31:0]   InstrD,
   output logic [31:0]   PCPlus8D,
   output logic          ValidD,
   output logic          FetchBusyF
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]   FetchCountF,
   output logic [31:0]   FetchStallCountF
`endif
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  req_addr_q, req_addr_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  pc8_q, pc8_d;
   logic         valid_q, valid_d;
   logic         redirect_s, ack_s;
   logic [31:0]  target_s;
   logic         fetch_load_s, skid_load_s, skid_clear_s, skid_xfer_s;
   logic         busy_s;
   logic [63:0]  skid_data_s;

   fetch_skid u_skid (
      .clk     (clk),
      .rst_n   (reset),
      .load_i  (skid_load_s),
      .clear_i (skid_clear_s),
      .data_i  ({req_addr_q, imem.ImemRdata}),
      .data_o  (skid_data_s)
   );

   // Next-state, PC and skid control.
   always_comb begin
      redirect_s   = PCSrcW | BranchTakenD;
      target_s     = PCSrcW ? ResultW : BranchTargetD;
      ack_s        = imem.ImemAck;
      state_d      = state_q;
      pc_d         = pc_q;
      req_addr_d   = req_addr_q;
      fetch_load_s = 1'b0;
      skid_load_s  = 1'b0;
      skid_clear_s = 1'b0;
      skid_xfer_s  = 1'b0;
      case (state_q)
         FS_IDLE: begin
            if (redirect_s) begin
               pc_d = target_s;
            end else if (!PCWrPendingF && !StallF) begin
               state_d    = FS_WAIT;
               req_addr_d = pc_q;
            end else begin
               state_d = FS_IDLE;
            end
         end
         FS_WAIT: begin
            if (redirect_s) begin
               pc_d    = target_s;
               state_d = ack_s ? FS_IDLE : FS_DROP;
            end else if (ack_s && FlushD) begin
               // Flushed word is refetched: PC is not advanced.
               state_d = FS_IDLE;
            end else if (ack_s && StallD) begin
               pc_d        = req_addr_q + PC_STEP;
               skid_load_s = 1'b1;
               state_d     = FS_FULL;
            end else if (ack_s) begin
               pc_d         = req_addr_q + PC_STEP;
               fetch_load_s = 1'b1;
               state_d      = FS_IDLE;
            end else begin
               state_d = FS_WAIT;
            end
         end
         FS_DROP: begin
            if (redirect_s) begin
               pc_d = target_s;
            end else begin
               pc_d = pc_q;
            end
            state_d = ack_s ? FS_IDLE : FS_DROP;
         end
         FS_FULL: begin
            if (redirect_s) begin
               pc_d         = target_s;
               skid_clear_s = 1'b1;
               state_d      = FS_IDLE;
            end else if (FlushD) begin
               skid_clear_s = 1'b1;
               state_d      = FS_IDLE;
            end else if (!StallD) begin
               skid_xfer_s  = 1'b1;
               skid_clear_s = 1'b1;
               state_d      = FS_IDLE;
            end else begin
               state_d = FS_FULL;
            end
         end
         default: begin
            state_d = FS_IDLE;
         end
      endcase
   end

   // IF/ID register next value: flush beats stall beats load; idle decode gets a bubble.
   always_comb begin
      instr_d = instr_q;
      pc8_d   = pc8_q;
      valid_d = valid_q;
      if (FlushD) begin
         instr_d = BUBBLE_INSTR;
         valid_d = 1'b0;
      end else if (StallD) begin
         valid_d = valid_q;
      end else if (fetch_load_s) begin
         instr_d = imem.ImemRdata;
         pc8_d   = req_addr_q + PC_STEP + PC_STEP;
         valid_d = 1'b1;
      end else if (skid_xfer_s) begin
         instr_d = skid_data_s[31:0];
         pc8_d   = skid_data_s[63:32] + PC_STEP + PC_STEP;
         valid_d = 1'b1;
      end else begin
         instr_d = BUBBLE_INSTR;
         valid_d = 1'b0;
      end
   end

   // State, PC, request address and IF/ID registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= FS_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= 32'h0;
         instr_q    <= BUBBLE_INSTR;
         pc8_q      <= 32'h0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         instr_q    <= instr_d;
         pc8_q      <= pc8_d;
         valid_q    <= valid_d;
      end
   end

   // Busy whenever decode cannot be handed an instruction this cycle.
   always_comb begin
      busy_s = 1'b0;
      case (state_q)
         FS_IDLE: busy_s = 1'b1;
         FS_WAIT: busy_s = ~ack_s;
         FS_DROP: busy_s = 1'b1;
         FS_FULL: busy_s = 1'b0;
         default: busy_s = 1'b1;
      endcase
   end

   assign imem.ImemReq  = (state_q == FS_WAIT) || (state_q == FS_DROP);
   assign imem.ImemAddr = req_addr_q;
   assign PCF           = pc_q;
   assign InstrD        = instr_q;
   assign PCPlus8D      = pc8_q;
   assign ValidD        = valid_q;
   assign FetchBusyF    = busy_s;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;

   // Saturating counters of IF/ID loads and busy cycles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt_q <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         if (!FlushD && !StallD && (fetch_load_s || skid_xfer_s)) begin
            fetch_cnt_q <= sat_inc(fetch_cnt_q);
         end else begin
            fetch_cnt_q <= fetch_cnt_q;
         end
         if (busy_s) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
         end else begin
            stall_cnt_q <= stall_cnt_q;
         end
      end
   end

   assign FetchCountF      = fetch_cnt_q;
   assign FetchStallCountF = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus hand sequences for flush and mid-request reset.
module tb_fetch_stage;
   import pipeline_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        StallF, StallD, FlushD, PCSrcW, BranchTakenD, PCWrPendingF;
   logic [31:0] ResultW, BranchTargetD;
   logic [31:0] PCF, InstrD, PCPlus8D;
   logic        ValidD, FetchBusyF;
`ifdef FETCH_PERF_EN
   logic [31:0] FetchCountF, FetchStallCountF;
`endif

   fetch_stage_if imem_bus ();

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .StallF        (StallF),
      .StallD        (StallD),
      .FlushD        (FlushD),
      .PCSrcW        (PCSrcW),
      .ResultW       (ResultW),
      .BranchTakenD  (BranchTakenD),
      .BranchTargetD (BranchTargetD),
      .PCWrPendingF  (PCWrPendingF),
      .imem          (imem_bus.master),
      .PCF           (PCF),
      .InstrD        (InstrD),
      .PCPlus8D      (PCPlus8D),
      .ValidD        (ValidD),
      .FetchBusyF    (FetchBusyF)
`ifdef FETCH_PERF_EN
      ,
      .FetchCountF      (FetchCountF),
      .FetchStallCountF (FetchStallCountF)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [31:0] A1 = 32'hE1A0_0001, A2 = 32'hE1A0_0002, A3 = 32'hE1A0_0003;
   localparam logic [31:0] A4 = 32'hE1A0_0004, A5 = 32'hE1A0_0005, A6 = 32'hE1A0_0006;
   localparam logic [31:0] A7 = 32'hE1A0_0007, BAD = 32'hBAD0_BAD0, DEAD = 32'hDEAD_BEEF;

   typedef struct {
      logic sf, sd, fl, ps; logic [31:0] res; logic bt; logic [31:0] btg;
      logic pw, ak; logic [31:0] rd;
      logic e_req; logic [31:0] e_addr; logic e_busy;
      logic [31:0] e_pcf, e_instr, e_pc8; logic e_valid;
   } vec_t;

   vec_t vq[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic sf, sd, fl, ps, input logic [31:0] res, input logic bt,
                      input logic [31:0] btg, input logic pw, ak, input logic [31:0] rd);
      StallF = sf; StallD = sd; FlushD = fl; PCSrcW = ps; ResultW = res;
      BranchTakenD = bt; BranchTargetD = btg; PCWrPendingF = pw;
      imem_bus.ImemAck = ak; imem_bus.ImemRdata = rd;
   endtask

   task automatic drs(input logic sd, fl, ak, input logic [31:0] rd);
      drv(1'b0, sd, fl, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, ak, rd);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string nm, input logic [31:0] pcf, instr, pc8, input logic v);
      chk({nm, ".PCF"}, PCF, pcf);
      chk({nm, ".InstrD"}, InstrD, instr);
      chk({nm, ".PCPlus8D"}, PCPlus8D, pc8);
      chk({nm, ".ValidD"}, {31'h0, ValidD}, {31'h0, v});
   endtask

   initial begin
      // sf sd fl ps res bt btg pw ak rd | req addr busy | pcf instr pc8 valid
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,  1'b0,32'h0,1'b1,  32'h0,32'h0,32'h0,1'b0});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,A1,     1'b1,32'h0,1'b0,  32'h4,A1,32'h8,1'b1});
      vq.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,  1'b0,32'h0,1'b1,  32'h4,A1,32'h8,1'b1});
      vq.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,A2,     1'b1,32'h4,1'b0,  32'h8,A1,32'h8,1'b1});
      vq.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,DEAD,   1'b0,32'h4,1'b0,  32'h8,A1,32'h8,1'b1});
      vq.push_back('{1'b0,1'b1,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,  1'b0,32'h4,1'b0,  32'h8,A1,32'h8,1'b1});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,  1'b0,32'h4,1'b0,  32'h8,A2,32'hC,1'b1});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,  1'b0,32'h4,1'b1,  32'h8,32'h0,32'hC,1'b0});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b1,32'h100,1'b0,1'b0,32'h0,1'b1,32'h8,1'b1,  32'h100,32'h0,32'hC,1'b0});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,  1'b1,32'h8,1'b1,  32'h100,32'h0,32'hC,1'b0});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,BAD,    1'b1,32'h8,1'b1,  32'h100,32'h0,32'hC,1'b0});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,  1'b0,32'h8,1'b1,  32'h100,32'h0,32'hC,1'b0});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,  1'b1,32'h100,1'b1,32'h100,32'h0,32'hC,1'b0});
      vq.push_back('{1'b0,1'b0,1'b0,1'b1,32'h200,1'b1,32'h100,1'b0,1'b0,32'h0,1'b1,32'h100,1'b1,32'h200,32'h0,32'hC,1'b0});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,BAD,    1'b1,32'h100,1'b1,32'h200,32'h0,32'hC,1'b0});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b1,32'hFFFF_FFFC,1'b0,1'b0,32'h0,1'b0,32'h100,1'b1,32'hFFFF_FFFC,32'h0,32'hC,1'b0});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,  1'b0,32'h100,1'b1,32'hFFFF_FFFC,32'h0,32'hC,1'b0});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b1,A3,     1'b1,32'hFFFF_FFFC,1'b0,32'h0,A3,32'h4,1'b1});
      vq.push_back('{1'b0,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b1,1'b0,32'h0,  1'b0,32'hFFFF_FFFC,1'b1,32'h0,32'h0,32'h4,1'b0});
      vq.push_back('{1'b1,1'b0,1'b0,1'b0,32'h0,1'b0,32'h0,1'b0,1'b0,32'h0,  1'b0,32'hFFFF_FFFC,1'b1,32'h0,32'h0,32'h4,1'b0});

      reset = 1'b0;
      drs(1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      tick();
      chk("rst.ImemReq", {31'h0, imem_bus.ImemReq}, 32'h0);
      chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
      reset = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         drv(vq[i].sf, vq[i].sd, vq[i].fl, vq[i].ps, vq[i].res, vq[i].bt, vq[i].btg,
             vq[i].pw, vq[i].ak, vq[i].rd);
         #1;
         chk($sformatf("v%0d.ImemReq", i), {31'h0, imem_bus.ImemReq}, {31'h0, vq[i].e_req});
         chk($sformatf("v%0d.ImemAddr", i), imem_bus.ImemAddr, vq[i].e_addr);
         chk($sformatf("v%0d.FetchBusyF", i), {31'h0, FetchBusyF}, {31'h0, vq[i].e_busy});
         tick();
         chk_ifid($sformatf("v%0d", i), vq[i].e_pcf, vq[i].e_instr, vq[i].e_pc8, vq[i].e_valid);
      end

      // Flush while the skid buffer is full and decode is stalled.
      drs(1'b0, 1'b0, 1'b0, 32'h0);  tick();
      drs(1'b0, 1'b0, 1'b1, A4);     tick();
      chk_ifid("fl.load", 32'h4, A4, 32'h8, 1'b1);
      drs(1'b1, 1'b0, 1'b0, 32'h0);  tick();
      drs(1'b1, 1'b0, 1'b1, A5);     tick();
      chk("fl.full.ImemReq", {31'h0, imem_bus.ImemReq}, 32'h0);
      chk("fl.full.skid_addr", dut.u_skid.data_o[63:32], 32'h4);
      chk("fl.full.skid_instr", dut.u_skid.data_o[31:0], A5);
      chk_ifid("fl.full", 32'h8, A4, 32'h8, 1'b1);
      drs(1'b1, 1'b1, 1'b0, 32'h0);  tick();
      chk_ifid("fl.flush", 32'h8, 32'h0, 32'h8, 1'b0);
      chk("fl.skid_addr", dut.u_skid.data_o[63:32], 32'h0);
      chk("fl.skid_instr", dut.u_skid.data_o[31:0], 32'h0);
      chk("fl.FetchBusyF", {31'h0, FetchBusyF}, 32'h1);

      // Reset asserted while a request is outstanding; the late ack must be ignored.
      drs(1'b0, 1'b0, 1'b0, 32'h0);  tick();
      drs(1'b0, 1'b0, 1'b1, A6);     tick();
      chk_ifid("rw.load", 32'hC, A6, 32'h10, 1'b1);
      drs(1'b1, 1'b0, 1'b0, 32'h0);  tick();
      chk("rw.wait.ImemReq", {31'h0, imem_bus.ImemReq}, 32'h1);
      chk("rw.wait.ImemAddr", imem_bus.ImemAddr, 32'hC);
      reset = 1'b0;
      #1;
      chk("rw.rst.ImemReq", {31'h0, imem_bus.ImemReq}, 32'h0);
      chk_ifid("rw.rst", 32'h0, 32'h0, 32'h0, 1'b0);
      drs(1'b0, 1'b0, 1'b1, DEAD);   tick();
      tick();
      reset = 1'b1;
      tick();
      chk_ifid("rw.stale", 32'h0, 32'h0, 32'h0, 1'b0);
      drs(1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      chk("rw.req.ImemReq", {31'h0, imem_bus.ImemReq}, 32'h1);
      chk("rw.req.ImemAddr", imem_bus.ImemAddr, 32'h0);
      tick();
      drs(1'b0, 1'b0, 1'b1, A7);     tick();
      chk_ifid("rw.fetch", 32'h4, A7, 32'h8, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports StallF, StallD and FlushD, each input, 1 bit: hazard-unit hold PC, hold IF/ID, and bubble IF/ID.
REQ-005 SHALL have ports PCSrcW (input, 1 bit) and ResultW (input, 32 bits): writeback redirect to R15.
REQ-006 SHALL have ports BranchTakenD (input, 1 bit) and BranchTargetD (input, 32 bits): early branch redirect from decode.
REQ-007 SHALL have port PCWrPendingF, input, 1 bit: suppresses new fetch requests.
REQ-008 SHALL have ports ImemReq (output, 1 bit), ImemAddr (output, 32 bits), ImemAck (input, 1 bit) and ImemRdata (input, 32 bits): instruction-memory request/ack pair.
REQ-009 SHALL have ports PCF (output, 32 bits), InstrD (output, 32 bits), PCPlus8D (output, 32 bits) and ValidD (output, 1 bit).
REQ-010 SHALL have port FetchBusyF, output, 1 bit: no instruction available for D this cycle.

Function
REQ-011 SHALL implement FSM states: IDLE (no request outstanding), WAIT (request outstanding), DROP (request outstanding, response discarded) and FULL (skid buffer holds an instruction).
REQ-012 SHALL keep ImemReq high in WAIT and DROP only, with ImemAddr held from an internal ReqAddr register stable until ImemAck.
REQ-013 SHALL move IDLE->WAIT with ReqAddr<=PCF when PCWrPendingF=0 and StallF=0.
REQ-014 SHALL, in WAIT on ImemAck with StallD=0: InstrD<=ImemRdata, PCPlus8D<=ReqAddr+8, ValidD<=1, PCF<=ReqAddr+4, then go to IDLE; back-to-back requests are issued the next cycle.
REQ-015 SHALL, in WAIT on ImemAck with StallD=1: capture ImemRdata and ReqAddr into the skid buffer and go to FULL.
REQ-016 SHALL, in FULL with StallD=0: load IF/ID from the skid buffer and go to IDLE; ImemReq stays low while in FULL.
REQ-017 SHALL apply redirect priority PCSrcW (target ResultW) > BranchTakenD (target BranchTargetD) > sequential.
REQ-018 SHALL load PCF with the redirect target on the next edge regardless of StallF.
REQ-019 SHALL, on redirect: WAIT without ack->DROP; WAIT with ack or FULL->IDLE with the data discarded.
REQ-020 SHALL, in DROP on ImemAck, discard the data and go to IDLE; a further redirect in DROP updates PCF only.
REQ-021 SHALL make FlushD force InstrD=32'h0 and ValidD=0 next edge, overriding StallD and skid transfer; the skid is discarded.
REQ-022 SHALL hold IF/ID with StallD=1 and FlushD=0.
REQ-023 SHALL drive FetchBusyF=1 in WAIT without ack, in DROP, and in IDLE.
REQ-024 SHALL ignore ImemAck in IDLE and FULL.
REQ-025 SHALL perform all PC arithmetic modulo 2^32, so 32'hFFFF_FFFC+4 wraps to 0.

Reset
REQ-026 SHALL, while reset=0, asynchronously force PCF=RESET_PC, InstrD=0, PCPlus8D=0, ValidD=0, ImemReq=0, state IDLE, and clear the skid buffer.
REQ-027 SHALL issue the first request in the first cycle after reset release.
REQ-028 SHALL ignore any ack belonging to a request interrupted by reset.

Configuration
REQ-029 SHALL, with FETCH_PERF_EN defined, add 32-bit outputs FetchCountF (ValidD loads) and FetchStallCountF (cycles FetchBusyF=1), saturating at 32'hFFFF_FFFF and reset to 0.
REQ-030 SHALL, without FETCH_PERF_EN, omit both the ports and the counters.

Structure
REQ-031 SHALL place the FSM state enum, the BUBBLE_INSTR=32'h0 constant and the PC_STEP=4 constant in shared package pipeline_pkg.
REQ-032 SHALL implement the skid buffer as sub-module fetch_skid (64-bit data+address register with load/clear).

Verification
REQ-033 SHALL verify: reset release, ImemAck same cycle as request -> ImemAddr=0, then InstrD=ImemRdata, PCPlus8D=8, PCF=4, ValidD=1.
REQ-034 SHALL verify: ack arrives with StallD=1 for 3 cycles -> FULL, ImemReq=0, InstrD unchanged; StallD drops -> InstrD=skid data.
REQ-035 SHALL verify: BranchTakenD with target 32'h100 while WAIT at 0x8, ack 2 cycles later -> data dropped, next ImemAddr=32'h100.
REQ-036 SHALL verify: PCSrcW (ResultW=32'h200) and BranchTakenD (32'h100) in the same cycle -> PCF=32'h200.
REQ-037 SHALL verify: FlushD with StallD=1 in FULL -> InstrD=0, ValidD=0, skid cleared.
REQ-038 SHALL verify: reset=0 asserted mid-WAIT -> outputs cleared immediately; stale ack ignored; PCF=RESET_PC.
